// File: rtl/seq_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_shifter_if                                               |
// | Description : Start/busy/done handshake and data bus for seq_shifter.      |
// |               The master issues operations; the slave (the shifter)        |
// |               reports progress and the result.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   start   master->slave  request, honoured only while the slave is idle    |
// |   a       master->slave  operand (WIDTH bits)                              |
// |   shamt   master->slave  shift amount (SHW bits, modulo WIDTH)             |
// |   dir     master->slave  0 = right, 1 = left                               |
// |   sra     master->slave  1 = arithmetic right (sign fill)                  |
// |   rotate  master->slave  1 = rotate, overrides sra                         |
// |   busy    slave->master  operation in progress                             |
// |   done    slave->master  one-cycle pulse, out1 holds the result            |
// |   out1    slave->master  result register (WIDTH bits)                      |
// +----------------------------------------------------------------------------+
interface seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic             dir;
  logic             sra;
  logic             rotate;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out1;

  modport master (
    output start, a, shamt, dir, sra, rotate,
    input  busy, done, out1
  );

  modport slave (
    input  start, a, shamt, dir, sra, rotate,
    output busy, done, out1
  );
endinterface
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_shifter                                                  |
// | Description : Multi-cycle shifter. Shifts an operand by 0..WIDTH-1 places  |
// |               left or right, one bit per clock, in logical, arithmetic    |
// |               right or rotate mode, behind a start/busy/done handshake.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   WIDTH   operand/result width in bits (>= 4)                              |
// |   SHW     width of the shift-amount field                                  |
// | Ports                                                                      |
// |   clk     system clock, rising edge                                        |
// |   rst     synchronous active-high reset; aborts an operation silently     |
// |   bus     seq_shifter_if.slave: start, a, shamt, dir, sra, rotate in;      |
// |           busy, done, out1 out                                             |
// | Build option                                                               |
// |   SEQ_SHIFTER_FAST_EN  when defined, steps of 4 bits are taken while at    |
// |                        least 4 places remain; results are unchanged,      |
// |                        latency becomes shamt/4 + shamt%4 + 1 cycles.      |
// +----------------------------------------------------------------------------+
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire          clk,
  input  wire          rst,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam logic [SHW-1:0] c_STEP1 = SHW'(1);
`ifdef SEQ_SHIFTER_FAST_EN
  // Compared one bit wider so WIDTH=4 (SHW=2) still has a representable 4.
  localparam logic [SHW:0]   c_FOUR  = (SHW+1)'(4);
  localparam logic [SHW-1:0] c_STEP4 = SHW'(4);
`endif

  // State and datapath registers
  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;
  logic             r_sra;
  logic             r_rot;

  // Combinational signals
  state_t           w_state_next;
  logic             w_accept;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_step1;
  logic [WIDTH-1:0] w_work_next;
  logic [SHW-1:0]   w_step_amt;
  logic [SHW-1:0]   w_cnt_next;
`ifdef SEQ_SHIFTER_FAST_EN
  logic [WIDTH-1:0] w_step4;
`endif

  // --------------------------------------------------------------------------
  // Single-bit step. sra only matters for a non-rotating right shift, which
  // falls out of the priority order below.
  // --------------------------------------------------------------------------
  always_comb begin
    w_step1 = r_work;
    if (r_dir) begin
      if (r_rot) w_step1 = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      else       w_step1 = {r_work[WIDTH-2:0], 1'b0};
    end else begin
      if (r_rot) w_step1 = {r_work[0], r_work[WIDTH-1:1]};
      else       w_step1 = {r_sra & r_work[WIDTH-1], r_work[WIDTH-1:1]};
    end
  end

`ifdef SEQ_SHIFTER_FAST_EN
  // Four-bit step with the same fill/rotate rules widened to 4 places.
  always_comb begin
    w_step4 = r_work;
    if (r_dir) begin
      if (r_rot) w_step4 = {r_work[WIDTH-5:0], r_work[WIDTH-1:WIDTH-4]};
      else       w_step4 = {r_work[WIDTH-5:0], 4'b0000};
    end else begin
      if (r_rot) w_step4 = {r_work[3:0], r_work[WIDTH-1:4]};
      else       w_step4 = {{4{r_sra & r_work[WIDTH-1]}}, r_work[WIDTH-1:4]};
    end
  end
`endif

  // Pick the step for this cycle and the matching counter decrement.
  always_comb begin
    w_work_next = w_step1;
    w_step_amt  = c_STEP1;
`ifdef SEQ_SHIFTER_FAST_EN
    if ({1'b0, r_cnt} >= c_FOUR) begin
      w_work_next = w_step4;
      w_step_amt  = c_STEP4;
    end
`endif
    w_cnt_next = r_cnt - w_step_amt;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          // A zero shift has no work to do; go straight to reporting.
          w_state_next = (bus.shamt != '0) ? S_SHIFT : S_FIN;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        // The step taken this cycle exhausts the count: it is the last one.
        if (w_cnt_next == '0) w_state_next = S_FIN;
      end
      S_FIN: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture on accept, step while shifting, hold otherwise so the
  // result stays visible from FIN until the next accepted start.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_sra  <= 1'b0;
      r_rot  <= 1'b0;
    end else if (w_accept) begin
      r_work <= bus.a;
      r_cnt  <= bus.shamt;
      r_dir  <= bus.dir;
      r_sra  <= bus.sra;
      r_rot  <= bus.rotate;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.out1 = r_work;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_shifter                                               |
// | Description : Self-checking bench for seq_shifter (WIDTH=32). Directed     |
// |               cases plus randomized operations checked against an         |
// |               arithmetic reference model.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  seq_shifter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain shift operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int n,
                                            input bit d, input bit s, input bit r);
    if (n == 0) return a;
    if (r) begin
      if (d) return (a << n) | (a >> (32 - n));
      else   return (a >> n) | (a << (32 - n));
    end
    if (d) return a << n;
    if (s) return 32'($signed(a) >>> n);
    return a >> n;
  endfunction

  // Cycles from the start edge to the done cycle.
  function automatic int exp_lat(input int n);
`ifdef SEQ_SHIFTER_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Issue one operation from IDLE (called at a negedge) and measure it.
  // Returns at a negedge with the DUT back in IDLE.
  task automatic do_op(input logic [31:0] a, input int n, input bit d, input bit s,
                       input bit r, output logic [31:0] res, output int lat,
                       output int bcnt, output logic post_done, output logic post_busy,
                       output logic [31:0] post_out);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.shamt  = SHW'(n);
    bus.dir    = d;
    bus.sra    = s;
    bus.rotate = r;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = $urandom;
    bus.shamt  = SHW'($urandom);
    bus.dir    = 1'($urandom);
    bus.sra    = 1'($urandom);
    bus.rotate = 1'($urandom);
    lat  = 0;
    bcnt = 0;
    res  = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        res = bus.out1;
        break;
      end
    end
    @(negedge clk);
    post_done = bus.done;
    post_busy = bus.busy;
    post_out  = bus.out1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a = '0; bus.shamt = '0; bus.dir = 0; bus.sra = 0; bus.rotate = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b out1=%h, want 0 0 00000000",
               bus.busy, bus.done, bus.out1);
    end
  endtask

  // Directed cases with known answers.
  task automatic test_directed();
    logic [31:0] ta [8]  = '{32'h12345678, 32'h87654321, 32'h87654321, 32'hFEDCBA98,
                             32'h01234567, 32'hC0FFEE01, 32'hABCDEFFF, 32'h80000000};
    int          tn [8]  = '{4, 4, 4, 8, 4, 4, 0, 31};
    bit          td [8]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    bit          ts [8]  = '{0, 1, 0, 1, 0, 0, 0, 1};
    bit          tr [8]  = '{0, 0, 0, 1, 0, 1, 0, 0};
    logic [31:0] tx [8]  = '{32'h01234567, 32'hF8765432, 32'h08765432, 32'h98FEDCBA,
                             32'h12345670, 32'h0FFEE01C, 32'hABCDEFFF, 32'hFFFFFFFF};
    logic [31:0] res, post_out;
    int          lat, bcnt;
    logic        pd, pb;
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tn[i], td[i], ts[i], tr[i], res, lat, bcnt, pd, pb, post_out);
      tests_run++;
      if (res !== tx[i]) begin
        tests_failed++;
        $display("FAIL directed%0d result: got %h want %h", i, res, tx[i]);
      end
      tests_run++;
      if (lat !== exp_lat(tn[i])) begin
        tests_failed++;
        $display("FAIL directed%0d latency: got %0d want %0d", i, lat, exp_lat(tn[i]));
      end
      tests_run++;
      if (bcnt !== exp_lat(tn[i]) - 1) begin
        tests_failed++;
        $display("FAIL directed%0d busy cycles: got %0d want %0d", i, bcnt, exp_lat(tn[i]) - 1);
      end
      tests_run++;
      if (pd !== 1'b0 || pb !== 1'b0 || post_out !== tx[i]) begin
        tests_failed++;
        $display("FAIL directed%0d after done: done=%b busy=%b out1=%h want 0 0 %h",
                 i, pd, pb, post_out, tx[i]);
      end
    end
  endtask

  // Randomized operations checked against the model.
  task automatic test_random();
    logic [31:0] a, res, post_out, exp;
    int          n, lat, bcnt;
    bit          d, s, r;
    logic        pd, pb;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      n = $urandom_range(0, 31);
      d = 1'($urandom); s = 1'($urandom); r = 1'($urandom);
      exp = ref_shift(a, n, d, s, r);
      do_op(a, n, d, s, r, res, lat, bcnt, pd, pb, post_out);
      tests_run++;
      if (res !== exp || lat !== exp_lat(n) || post_out !== exp) begin
        tests_failed++;
        $display("FAIL random%0d a=%h n=%0d d=%b s=%b r=%b: out1=%h lat=%0d hold=%h want %h lat=%0d",
                 i, a, n, d, s, r, res, lat, post_out, exp, exp_lat(n));
      end
    end
  endtask

  // A start pulsed mid-operation must not disturb it.
  task automatic test_ignore_start();
    logic [31:0] a, exp, res;
    int          lat;
    a   = 32'h13579BDF;
    exp = ref_shift(a, 16, 0, 1, 0);
    bus.start = 1'b1; bus.a = a; bus.shamt = SHW'(16);
    bus.dir = 0; bus.sra = 1; bus.rotate = 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    res = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        // Presented for the edge that begins cycle 3.
        bus.start = 1'b1; bus.a = 32'hF0F0F0F0; bus.shamt = SHW'(1);
        bus.dir = 1; bus.sra = 0; bus.rotate = 1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        res = bus.out1;
        break;
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (res !== exp || lat !== exp_lat(16)) begin
      tests_failed++;
      $display("FAIL ignore_start: out1=%h lat=%0d want %h lat=%0d", res, lat, exp, exp_lat(16));
    end
    @(negedge clk);
  endtask

  // Reset mid-operation: outputs clear and no done pulse follows.
  task automatic test_abort_reset();
    int dones;
    bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.shamt = SHW'(20);
    bus.dir = 1; bus.sra = 0; bus.rotate = 1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_reset state: busy=%b done=%b out1=%h want 0 0 00000000",
               bus.busy, bus.done, bus.out1);
    end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_reset done pulses: got %0d want 0", dones);
    end
  endtask

  // Operations issued as soon as the block returns to IDLE.
  task automatic test_back_to_back();
    logic [31:0] a, res, post_out, exp;
    int          n, lat, bcnt;
    logic        pd, pb;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      n = (i == 0) ? 31 : $urandom_range(1, 31);
      exp = ref_shift(a, n, i[0], 1'b1, i[1]);
      do_op(a, n, i[0], 1'b1, i[1], res, lat, bcnt, pd, pb, post_out);
      tests_run++;
      if (res !== exp || lat !== exp_lat(n)) begin
        tests_failed++;
        $display("FAIL back_to_back%0d: out1=%h lat=%0d want %h lat=%0d", i, res, lat, exp, exp_lat(n));
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shifter. It is the successor to the single-step 32-bit op2bit shift/rotate block.
- Shifts an operand by a programmable amount (0..WIDTH-1) in either direction, one bit per clock.
- Supports logical, arithmetic-right and rotate modes.
- Uses a start/busy/done handshake.
- Sits beside the ALU datapath and serves shift instructions that need more than a 1-bit step.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), width of the shift-amount field

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand, captured on accepted start
shamt  input  SHW  shift amount, captured on accepted start
dir  input  1  0 = right, 1 = left; captured on accepted start
sra  input  1  1 = arithmetic right (sign fill); captured on accepted start
rotate  input  1  1 = rotate; overrides sra; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, result valid
out1  output  WIDTH  result register

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, busy=0, done=0, out1=0, counter=0. Reset aborts any operation in progress; no done pulse is produced for it.
- State machine: IDLE, SHIFT, FIN.
- IDLE + start=1:
  - Latch a into out1 (working register).
  - Latch shamt into the counter.
  - Latch dir/sra/rotate into the mode register.
  - busy=1.
  - Next state is SHIFT if shamt!=0, else FIN.
- SHIFT, one 1-bit step per cycle, counter decrements each step:
  - Right, logical: {0, r[W-1:1]}.
  - Right, arithmetic: {r[W-1], r[W-1:1]}.
  - Right, rotate: {r[0], r[W-1:1]}.
  - Left, logical: {r[W-2:0], 0}.
  - Left, rotate: {r[W-2:0], r[W-1]}.
  - sra is ignored when dir=1 or rotate=1.
  - When the counter reaches 1, the final step executes and the next state is FIN.
- FIN (one cycle): done=1, busy=0. Next state is IDLE.
  - out1 holds its final value through FIN and stays there until the next accepted start.
- Latency: done is high in the (shamt+1)th cycle after the start edge. For shamt=0 this is 1 cycle, with out1=a.
- start while busy=1: ignored; the operation in flight is unaffected.
- start during FIN: ignored, because busy=0 is only meaningful in IDLE. A new start must be presented in IDLE.
- Inputs are don't-care except when start is accepted.
- out1 shows intermediate values during SHIFT. Consumers use it only when done=1 or in IDLE.
- Shift amounts are modulo WIDTH because shamt is SHW bits wide.

Optional Feature:
SEQ_SHIFTER_FAST_EN
- Defined: in SHIFT, while counter>=4, the block performs a 4-bit step in the same mode (fill/rotate rules extended to 4 bits) and subtracts 4 from the counter. Remaining steps are 1-bit.
  - Latency = floor(shamt/4) + (shamt mod 4) + 1 cycles.
  - Final results are identical to the 1-bit-per-cycle build.
- Undefined: 1-bit steps only; latency = shamt+1.

Test Plan:
All cases use WIDTH=32, 1-bit build.
1. a=0x12345678, shamt=4, dir=0, sra=0, rotate=0 -> done in cycle 5 after start, out1=0x01234567; busy high for 4 cycles.
2. a=0x87654321, shamt=4, dir=0, sra=1 -> out1=0xF8765432. Repeat with sra=0 -> 0x08765432.
3. a=0xFEDCBA98, shamt=8, dir=0, rotate=1, sra=1 -> out1=0x98FEDCBA (rotate overrides sra).
4. a=0x01234567, shamt=4, dir=1 -> out1=0x12345670. a=0xC0FFEE01, shamt=4, dir=1, rotate=1 -> out1=0x0FFEE01C.
5. a=0xABCDEFFF, shamt=0 -> done 1 cycle after start, out1=0xABCDEFFF. shamt=31, a=0x80000000, dir=0, sra=1 -> out1=0xFFFFFFFF, done at cycle 32.
6. Robustness:
   - Start a shamt=16 op, pulse start again with a=0xF0F0F0F0 at cycle 3 -> ignored, original result unaffected.
   - Start another op, assert rst at cycle 5 -> next cycle busy=0, done=0, out1=0, no done pulse.
   - A subsequent start works normally.
